// File: rtl/ofs_plat_axi_split_pkg.sv
// Shared types and helpers for the AXI page splitters (read side today, write side later).
// The localparams describe the default platform configuration used by the splitter tops.
package ofs_plat_axi_split_pkg;

    localparam int DATA_BYTES    = 512 / 8;
    localparam int PAGE_IDX_BITS = $clog2(4096);
    localparam int OUT_LEN_WIDTH = $clog2(16);

    // Wide enough for any beat count derived from an 8..31 bit AXI len.
    typedef logic [31:0] t_beats;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } t_split_state;

    function automatic t_beats min3(input t_beats a, input t_beats b, input t_beats c);
        t_beats m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/ofs_plat_axi_split_len_calc.sv
// Size of the next sub-burst: limited by the beats left in the request, the beats left
// before the next page boundary and the maximum emitted burst size.
module ofs_plat_axi_split_len_calc
    import ofs_plat_axi_split_pkg::*;
#(
    parameter int ADDR_WIDTH    = 64,
    parameter int BEAT_BYTES    = 64,
    parameter int PAGE_BYTES    = 4096,
    parameter int MAX_OUT_BEATS = 16,
    parameter int CNT_WIDTH     = 9
)(
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [CNT_WIDTH-1:0]  remaining,
    output logic [CNT_WIDTH-1:0]  sub,
    output logic                  is_final
);

    localparam int     BEAT_BITS  = $clog2(BEAT_BYTES);
    localparam int     PAGE_BITS  = $clog2(PAGE_BYTES);
    localparam t_beats PAGE_BEATS = t_beats'(PAGE_BYTES / BEAT_BYTES);
    localparam t_beats MAX_BEATS  = t_beats'(MAX_OUT_BEATS);

    logic [PAGE_BITS-BEAT_BITS-1:0] page_beat_idx;
    t_beats                         page_beats_left;
    t_beats                         sub_wide;
    logic                           unused_bits;

    // Beat index within the page; the byte offset below a beat is always zero.
    assign page_beat_idx   = addr[PAGE_BITS-1:BEAT_BITS];
    assign page_beats_left = PAGE_BEATS - t_beats'(page_beat_idx);
    assign sub_wide        = min3(t_beats'(remaining), page_beats_left, MAX_BEATS);

    assign sub      = sub_wide[CNT_WIDTH-1:0];
    assign is_final = (sub == remaining);

    assign unused_bits = ^{addr[ADDR_WIDTH-1:PAGE_BITS], addr[BEAT_BITS-1:0],
                           sub_wide[$bits(t_beats)-1:CNT_WIDTH]};

endmodule

// File: rtl/ofs_plat_axi_mem_read_page_splitter.sv
// Splits AXI read bursts into sub-bursts that never cross a page and never exceed
// MAX_OUT_BEATS; an extra user bit marks the final sub-burst so RLAST can be rebuilt.
module ofs_plat_axi_mem_read_page_splitter
    import ofs_plat_axi_split_pkg::*;
#(
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = DATA_BYTES * 8,
    parameter int ID_WIDTH      = 9,
    parameter int USER_WIDTH    = 4,
    parameter int LEN_WIDTH     = 8,
    parameter int MAX_OUT_BEATS = 1 << OUT_LEN_WIDTH,
    parameter int PAGE_BYTES    = 1 << PAGE_IDX_BITS
)(
    input  logic                               clk,
    input  logic                               reset_n,

    input  logic                               s_ar_valid,
    output logic                               s_ar_ready,
    input  logic [ADDR_WIDTH-1:0]              s_ar_addr,
    input  logic [LEN_WIDTH-1:0]               s_ar_len,
    input  logic [ID_WIDTH-1:0]                s_ar_id,
    input  logic [USER_WIDTH-1:0]              s_ar_user,

    output logic                               m_ar_valid,
    input  logic                               m_ar_ready,
    output logic [ADDR_WIDTH-1:0]              m_ar_addr,
    output logic [$clog2(MAX_OUT_BEATS)-1:0]   m_ar_len,
    output logic [ID_WIDTH-1:0]                m_ar_id,
    output logic [USER_WIDTH:0]                m_ar_user,

    input  logic                               m_r_valid,
    output logic                               m_r_ready,
    input  logic [DATA_WIDTH-1:0]              m_r_data,
    input  logic [1:0]                         m_r_resp,
    input  logic [ID_WIDTH-1:0]                m_r_id,
    input  logic [USER_WIDTH:0]                m_r_user,
    input  logic                               m_r_last,

    output logic                               s_r_valid,
    input  logic                               s_r_ready,
    output logic [DATA_WIDTH-1:0]              s_r_data,
    output logic [1:0]                         s_r_resp,
    output logic [ID_WIDTH-1:0]                s_r_id,
    output logic [USER_WIDTH-1:0]              s_r_user,
    output logic                               s_r_last,

    output t_split_state                       split_state
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int BEAT_BITS  = $clog2(BEAT_BYTES);
    localparam int LEN_OUT_W  = $clog2(MAX_OUT_BEATS);
    localparam int CNT_WIDTH  = LEN_WIDTH + 1;

    t_split_state           state_q;
    t_split_state           state_d;
    logic                   ready_en_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [CNT_WIDTH-1:0]   remain_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [USER_WIDTH-1:0]  user_q;

    logic [CNT_WIDTH-1:0]   sub;
    logic [CNT_WIDTH-1:0]   sub_m1;
    logic                   is_final;
    logic                   ar_accept;
    logic                   m_ar_fire;
    logic                   unused_len_bits;

    ofs_plat_axi_split_len_calc #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .BEAT_BYTES    (BEAT_BYTES),
        .PAGE_BYTES    (PAGE_BYTES),
        .MAX_OUT_BEATS (MAX_OUT_BEATS),
        .CNT_WIDTH     (CNT_WIDTH)
    ) len_calc (
        .addr      (addr_q),
        .remaining (remain_q),
        .sub       (sub),
        .is_final  (is_final)
    );

    // Handshakes: a transfer happens on a clock edge where valid & ready are both high.
    // valid never depends on ready; payload is held while valid is high and ready is low.
    assign ar_accept = s_ar_valid & s_ar_ready;
    assign m_ar_fire = m_ar_valid & m_ar_ready;

    always_comb begin
        state_d    = state_q;
        s_ar_ready = 1'b0;
        m_ar_valid = 1'b0;
        case (state_q)
            IDLE: begin
                s_ar_ready = ready_en_q;
                if (s_ar_valid && ready_en_q) begin
                    state_d = SPLIT;
                end
            end
            SPLIT: begin
                m_ar_valid = 1'b1;
                // Final sub-burst leaving: take the next request in the same cycle.
                if (m_ar_ready && is_final) begin
                    s_ar_ready = ready_en_q;
                    state_d    = (s_ar_valid && ready_en_q) ? SPLIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ready_en_q <= 1'b0;
            addr_q     <= '0;
            remain_q   <= '0;
            id_q       <= '0;
            user_q     <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            if (ar_accept) begin
                addr_q   <= s_ar_addr;
                remain_q <= {1'b0, s_ar_len} + CNT_WIDTH'(1);
                id_q     <= s_ar_id;
                user_q   <= s_ar_user;
            end else if (m_ar_fire) begin
                addr_q   <= addr_q + (ADDR_WIDTH'(sub) << BEAT_BITS);
                remain_q <= remain_q - sub;
            end
        end
    end

    assign sub_m1      = sub - CNT_WIDTH'(1);
    assign m_ar_addr   = addr_q;
    assign m_ar_len    = sub_m1[LEN_OUT_W-1:0];
    assign m_ar_id     = id_q;
    assign m_ar_user   = {is_final, user_q};
    assign split_state = state_q;

    assign unused_len_bits = ^sub_m1[CNT_WIDTH-1:LEN_OUT_W];

    // Response path carries no state, so any ID interleaving passes straight through.
    assign s_r_valid = m_r_valid;
    assign m_r_ready = s_r_ready;
    assign s_r_data  = m_r_data;
    assign s_r_resp  = m_r_resp;
    assign s_r_id    = m_r_id;
    assign s_r_user  = m_r_user[USER_WIDTH-1:0];
    assign s_r_last  = m_r_last & m_r_user[USER_WIDTH];

    unaligned_addr: assert property (@(posedge clk) disable iff (!reset_n)
        ar_accept |-> (s_ar_addr[BEAT_BITS-1:0] == '0));

endmodule
